// File: rtl/note_sequencer_if.sv
// -----------------------------------------------------------------------------
// note_sequencer_if
// Bundles the note sequencer's two external buses:
//   - the note ROM: rom_addr out, rom_q back
//   - the audio controller's DAC FIFO: sample_out and write_audio_out out,
//     audio_out_allowed back
// Ports (interface signals):
//   rom_addr          [ADDR_W-1:0]  note ROM address
//   rom_q             [18:0]        half-period in clocks; 0 = rest; all ones = end
//   audio_out_allowed               DAC FIFO has space
//   sample_out        [31:0]        signed sample (two's complement)
//   write_audio_out                 sample write strobe
// Modports: master = the sequencer, slave = the ROM/FIFO side.
// -----------------------------------------------------------------------------
interface note_sequencer_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0]  rom_addr;
    logic [18:0]        rom_q;
    logic               audio_out_allowed;
    logic signed [31:0] sample_out;
    logic               write_audio_out;

    modport master (
        output rom_addr,
        output sample_out,
        output write_audio_out,
        input  rom_q,
        input  audio_out_allowed
    );

    modport slave (
        input  rom_addr,
        input  sample_out,
        input  write_audio_out,
        output rom_q,
        output audio_out_allowed
    );
endinterface

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Steps through an external note ROM, one entry per beat, and synthesises a
// square wave whose half-period (in clocks) comes from the ROM. The resulting
// signed samples are offered to the DAC FIFO on every busy cycle that the
// FIFO has room; the sequencer never stalls, so samples offered while the
// FIFO is full are simply dropped.
// Ports:
//   CLOCK_50   system clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse: begin playback at address 0 (ignored when busy)
//   stop       one-cycle pulse: abort playback (no done pulse)
//   loop_en    1 = wrap to address 0 after LAST_ADDR, 0 = finish
//   vol_shift  amplitude = AMPLITUDE >>> vol_shift
//   bus        ROM and DAC FIFO signals (note_sequencer_if.master)
//   busy       high outside IDLE
//   done       one-cycle pulse on natural completion
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int LAST_ADDR   = 999,
    parameter int BEAT_CYCLES = 2500000,
    parameter int AMPLITUDE   = 100000000,
    parameter int ROM_LATENCY = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [2:0]       vol_shift,
    note_sequencer_if.master bus,
    output logic             busy,
    output logic             done
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int WAIT_W = $clog2(ROM_LATENCY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LAST_NOTE  = ADDR_W'(LAST_ADDR);
    localparam logic [18:0]       END_MARK   = 19'h7FFFF;
    localparam logic signed [31:0] AMP_FULL  = 32'(AMPLITUDE);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [18:0]         phase_q, phase_d;
    logic [18:0]         half_q, half_d;
    logic                snd_q, snd_d;
    logic signed [31:0]  sample_q, sample_d;
    logic                done_q, done_d;

    logic signed [31:0]  amp;
    logic                rest;

    assign amp  = AMP_FULL >>> vol_shift;
    assign rest = (half_q == '0);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred; blocking '=' is used
    // because this is combinational logic evaluated top to bottom.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        phase_d  = phase_q;
        half_d   = half_q;
        snd_d    = snd_q;
        sample_d = sample_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sample_d = '0;
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    state_d = FETCH;
                    addr_d  = '0;
                    wait_d  = '0;
                end
            end

            FETCH: begin
                if (stop) begin
                    state_d  = IDLE;
                    addr_d   = '0;
                    sample_d = '0;
                end else if (wait_q == LAST_WAIT) begin
                    // rom_q has settled for the current address: latch it and
                    // start the beat with the wave in its positive half
                    half_d  = bus.rom_q;
                    phase_d = '0;
                    beat_d  = '0;
                    snd_d   = 1'b1;
                    if (bus.rom_q == END_MARK) begin
                        state_d  = IDLE;
                        addr_d   = '0;
                        sample_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            PLAY: begin
                if (stop) begin
                    state_d  = IDLE;
                    addr_d   = '0;
                    sample_d = '0;
                end else begin
                    // sample follows snd with one clock of latency
                    if (rest) begin
                        sample_d = '0;
                    end else begin
                        sample_d = snd_q ? amp : -amp;
                        // phase spans 0..half_period, so a full square period
                        // is 2*(half_period+1) clocks
                        if (phase_q == half_q) begin
                            phase_d = '0;
                            snd_d   = ~snd_q;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end

                    if (beat_q == LAST_BEAT) begin
                        wait_d = '0;
                        if (addr_q < LAST_NOTE) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end else if (loop_en) begin
                            addr_d  = '0;
                            state_d = FETCH;
                        end else begin
                            state_d  = IDLE;
                            addr_d   = '0;
                            sample_d = '0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous and sampled only at the clock edge, so it is
    // an ordinary priority branch here rather than part of the sensitivity
    // list; state updates use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wait_q   <= '0;
            beat_q   <= '0;
            phase_q  <= '0;
            half_q   <= '0;
            snd_q    <= 1'b1;
            sample_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            phase_q  <= phase_d;
            half_q   <= half_d;
            snd_q    <= snd_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign busy                = (state_q != IDLE);
    assign done                = done_q;
    assign bus.rom_addr        = addr_q;
    assign bus.sample_out      = sample_q;
    // samples are offered every busy cycle; a full FIFO just drops them
    assign bus.write_audio_out = busy & bus.audio_out_allowed;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Self-checking bench for note_sequencer with a small beat (20 clocks), four
// ROM entries and AMPLITUDE=1000. A behavioural model tracks, per note, the
// cycle position inside the note and derives the square wave directly from
// position / (half_period+1); one compare process checks every output on
// every falling edge. Directed scenarios pin the model with literal values,
// then a randomized phase exercises start/stop/reset/loop/volume/backpressure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_sequencer;

    localparam int ADDR_W    = 10;
    localparam int LAST_ADDR = 3;
    localparam int BEAT      = 20;
    localparam int AMPL      = 1000;
    localparam int LAT       = 2;
    localparam int END_MARK  = 'h7FFFF;

    logic       CLOCK_50  = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic       loop_en   = 1'b0;
    logic [2:0] vol_shift = 3'd0;
    logic       allowed   = 1'b1;
    logic       busy;
    logic       done;

    logic [18:0] rom_mem [0:3];
    logic [18:0] rom_q_r;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;
    int done_cnt = 0;
    int max_addr = 0;

    note_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    note_sequencer #(
        .ADDR_W      (ADDR_W),
        .LAST_ADDR   (LAST_ADDR),
        .BEAT_CYCLES (BEAT),
        .AMPLITUDE   (AMPL),
        .ROM_LATENCY (LAT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .vol_shift (vol_shift),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // ROM model: one registered stage, so data is valid well inside the
    // two-clock fetch window
    always @(posedge CLOCK_50) begin
        if (bus.rom_addr <= ADDR_W'(LAST_ADDR)) rom_q_r <= rom_mem[bus.rom_addr[1:0]];
        else                                    rom_q_r <= '0;
    end
    assign bus.rom_q             = rom_q_r;
    assign bus.audio_out_allowed = allowed;

    // ------------------------------------------------------------------
    // Behavioural model: m_pos counts clocks since the note began
    // (0..LAT-1 = fetching, LAT.. = sounding).
    // ------------------------------------------------------------------
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;
    int m_addr   = 0;
    int m_pos    = 0;
    int m_half   = 0;
    int m_sample = 0;
    int m_amp;
    int m_i;

    task automatic m_to_idle(input bit with_done);
        m_busy   = 1'b0;
        m_addr   = 0;
        m_pos    = 0;
        m_sample = 0;
        m_done   = with_done;
    endtask

    always @(posedge CLOCK_50) begin
        m_amp  = AMPL >>> vol_shift;
        m_done = 1'b0;
        if (reset) begin
            m_to_idle(1'b0);
            m_half = 0;
        end else if (!m_busy) begin
            m_sample = 0;
            if (start && !stop) begin
                m_busy = 1'b1;
                m_addr = 0;
                m_pos  = 0;
            end
        end else if (stop) begin
            m_to_idle(1'b0);
        end else if (m_pos < LAT) begin
            if (m_pos == LAT - 1) begin
                m_half = int'(rom_mem[m_addr]);
                if (m_half == END_MARK) m_to_idle(1'b1);
                else                    m_pos = m_pos + 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            m_i = m_pos - LAT;
            if (m_half == 0)                       m_sample = 0;
            else if (((m_i / (m_half + 1)) % 2) == 0) m_sample = m_amp;
            else                                   m_sample = -m_amp;
            if (m_i == BEAT - 1) begin
                if (m_addr < LAST_ADDR) begin
                    m_addr = m_addr + 1;
                    m_pos  = 0;
                end else if (loop_en) begin
                    m_addr = 0;
                    m_pos  = 0;
                end else begin
                    m_to_idle(1'b1);
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("busy",     longint'(busy),                m_busy);
            check("done",     longint'(done),                m_done);
            check("rom_addr", longint'(bus.rom_addr),        m_addr);
            check("sample",   longint'(bus.sample_out),      m_sample);
            check("write",    longint'(bus.write_audio_out), m_busy & allowed);
            if (done === 1'b1) done_cnt = done_cnt + 1;
            if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
        end
    end

    // inputs change 1 ns after the rising edge
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // waits for the falling edge of cycle n
    task automatic goto(input int n);
        do @(negedge CLOCK_50); while (cyc < n);
    endtask

    // base = first cycle after the edge that samples start
    task automatic pulse_start(output int base);
        tick();
        start = 1'b1;
        base  = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic load_rom(input int a, input int b, input int c, input int d);
        rom_mem[0] = 19'(a);
        rom_mem[1] = 19'(b);
        rom_mem[2] = 19'(c);
        rom_mem[3] = 19'(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int d0;
        load_rom(4, 0, 2, 9);
        repeat (3) tick();
        cmp_en = 1'b1;
        goto(cyc);
        check("reset_busy",   longint'(busy),           0);
        check("reset_addr",   longint'(bus.rom_addr),   0);
        check("reset_sample", longint'(bus.sample_out), 0);
        tick();
        reset = 1'b0;

        // normal one-shot playback
        d0 = done_cnt;
        pulse_start(base);
        goto(base + 2);  check("s1_hold",   longint'(bus.sample_out), 0);
        goto(base + 3);  check("s1_first",  longint'(bus.sample_out), 1000);
        goto(base + 7);  check("s1_pos5",   longint'(bus.sample_out), 1000);
        goto(base + 8);  check("s1_neg",    longint'(bus.sample_out), -1000);
        goto(base + 30); check("s1_rest",   longint'(bus.sample_out), 0);
        goto(base + 50); check("s1_note2",  longint'(bus.sample_out), -1000);
        goto(base + 79); check("s1_note3",  longint'(bus.sample_out), -1000);
        goto(base + 87); check("s1_nodone", longint'(done), 0);
        goto(base + 88); check("s1_done",   longint'(done), 1);
        goto(base + 89);
        check("s1_idle",     longint'(busy),           0);
        check("s1_idle_smp", longint'(bus.sample_out), 0);
        check("s1_done_cnt", done_cnt - d0,            1);

        // looping playback
        loop_en = 1'b1;
        d0 = done_cnt;
        pulse_start(base);
        goto(base + 22);  check("s2_addr1",   longint'(bus.rom_addr), 1);
        goto(base + 44);  check("s2_addr2",   longint'(bus.rom_addr), 2);
        goto(base + 66);  check("s2_addr3",   longint'(bus.rom_addr), 3);
        goto(base + 88);  check("s2_wrap",    longint'(bus.rom_addr), 0);
        goto(base + 92);  check("s2_restart", longint'(bus.sample_out), 1000);
        goto(base + 110); check("s2_addr1b",  longint'(bus.rom_addr), 1);
        check("s2_no_done", done_cnt - d0, 0);
        pulse_stop();
        loop_en = 1'b0;

        // end-of-song marker in entry 1
        load_rom(4, END_MARK, 2, 9);
        max_addr = 0;
        pulse_start(base);
        goto(base + 23); check("s3_busy",  longint'(busy), 1);
        goto(base + 24); check("s3_done",  longint'(done), 1);
        check("s3_idle", longint'(busy), 0);
        goto(base + 30); check("s3_max_addr", max_addr, 1);

        // stop in the middle of note 2
        load_rom(4, 0, 2, 9);
        d0 = done_cnt;
        pulse_start(base);
        goto(base + 49);
        tick();
        stop = 1'b1;
        goto(base + 50); check("s4_playing", longint'(busy), 1);
        tick();
        stop = 1'b0;
        goto(base + 51);
        check("s4_busy",   longint'(busy),           0);
        check("s4_sample", longint'(bus.sample_out), 0);
        check("s4_addr",   longint'(bus.rom_addr),   0);
        check("s4_done",   done_cnt - d0,            0);

        // start and stop together from IDLE
        tick();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        base  = cyc;
        goto(base);     check("s5_busy",  longint'(busy), 0);
        goto(base + 3); check("s5_busy3", longint'(busy), 0);

        // volume shift, backpressure, start while busy
        vol_shift = 3'd3;
        pulse_start(base);
        goto(base + 3); check("s6_vol_pos", longint'(bus.sample_out), 125);
        goto(base + 8); check("s6_vol_neg", longint'(bus.sample_out), -125);
        goto(base + 9);
        tick();
        allowed = 1'b0;
        goto(base + 10); check("s6_bp_write", longint'(bus.write_audio_out), 0);
        repeat (7) tick();
        allowed = 1'b1;
        goto(base + 17); check("s6_bp_resume", longint'(bus.write_audio_out), 1);
        goto(base + 19);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        goto(base + 87); check("s6_nodone", longint'(done), 0);
        goto(base + 88); check("s6_done",   longint'(done), 1);
        vol_shift = 3'd0;

        // reset during the fetch of note 1
        pulse_start(base);
        goto(base + 21);
        tick();
        reset = 1'b1;
        goto(base + 22);
        check("s7_fetch_addr",   longint'(bus.rom_addr),   1);
        check("s7_fetch_sample", longint'(bus.sample_out), -1000);
        tick();
        reset = 1'b0;
        goto(base + 23);
        check("s7_rst_busy",   longint'(busy),           0);
        check("s7_rst_addr",   longint'(bus.rom_addr),   0);
        check("s7_rst_sample", longint'(bus.sample_out), 0);
        check("s7_rst_done",   longint'(done),           0);
        pulse_start(base);
        goto(base + 1);  check("s7_replay_addr", longint'(bus.rom_addr), 0);
        goto(base + 3);  check("s7_replay_smp",  longint'(bus.sample_out), 1000);
        goto(base + 88); check("s7_replay_done", longint'(done), 1);

        // randomized traffic, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!m_busy && ($urandom_range(0, 3) == 0)) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 7) == 0) rom_mem[k] = 19'(END_MARK);
                    else                           rom_mem[k] = 19'($urandom_range(0, 6));
                end
            end
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 149) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            loop_en   = $urandom_range(0, 1);
            vol_shift = 3'($urandom_range(0, 7));
            allowed   = ($urandom_range(0, 3) != 0);
        end
        tick();
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        goto(cyc + 2);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream tone source for the board audio path: steps through an external note ROM, one entry per beat, and synthesises a square wave whose half-period comes from the ROM.
- Presents signed 32-bit samples with a write strobe to the audio controller's DAC FIFO interface, gated by audio_out_allowed.
- Supports one-shot or looping playback, abort, rests, an end-of-song marker and a volume shift.

Parameters:
- ADDR_W, 10, note ROM address width.
- LAST_ADDR, 999, final ROM address played before wrap or finish.
- BEAT_CYCLES, 2500000, clocks per note (beat length).
- AMPLITUDE, 100000000, peak sample magnitude at vol_shift=0.
- ROM_LATENCY, 2, clocks from rom_addr change to valid rom_q.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins playback at address 0.
- stop  input  1  single-cycle pulse; aborts playback.
- loop_en  input  1  1 = wrap to address 0 after LAST_ADDR; 0 = finish.
- vol_shift  input  3  amplitude = AMPLITUDE >>> vol_shift.
- rom_addr  output  ADDR_W  note ROM address.
- rom_q  input  19  half-period in clocks; 0 = rest; 19'h7FFFF = end marker.
- audio_out_allowed  input  1  DAC FIFO has space.
- sample_out  output  32  signed sample (two's complement).
- write_audio_out  output  1  sample write strobe.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse on natural completion.

Behaviour:
- Reset (synchronous, dominates all inputs): state=IDLE; rom_addr=0; sample_out=0; done=0; busy=0; all counters=0; snd=1.
- States: IDLE, FETCH, PLAY.
- IDLE:
  - sample_out=0.
  - start -> FETCH with rom_addr=0.
  - stop is ignored.
- FETCH:
  - Waits exactly ROM_LATENCY cycles.
  - On the last wait cycle, latches rom_q into half_period. Clears phase_cnt and beat_cnt, sets snd=1, then enters PLAY.
  - If the latched value is 19'h7FFFF: go to IDLE instead and pulse done, with no PLAY cycles.
  - sample_out holds its previous value during FETCH.
- PLAY:
  - beat_cnt counts 0..BEAT_CYCLES-1.
  - If half_period != 0: phase_cnt counts 0..half_period, then returns to 0 and toggles snd. One square period is 2*(half_period+1) clocks.
  - If half_period == 0 (rest): snd is frozen and sample_out=0.
  - At beat_cnt==BEAT_CYCLES-1:
    - If rom_addr<LAST_ADDR: rom_addr+1 -> FETCH.
    - Else if loop_en: rom_addr=0 -> FETCH.
    - Else: IDLE, done=1 for one cycle, sample_out=0.
  - loop_en is sampled only at that last-beat cycle.
- Sample register (updated every PLAY cycle, one-cycle latency from snd):
  - sample_out = rest ? 0 : (snd ? +amp : -amp), where amp = AMPLITUDE >>> vol_shift.
  - Arithmetic is 32-bit with no saturation; AMPLITUDE must be < 2^31.
  - vol_shift takes effect on the next sample register update.
- write_audio_out = busy & audio_out_allowed (combinational).
  - The sequencer never stalls on backpressure; samples are dropped while audio_out_allowed=0.
- stop in FETCH or PLAY:
  - Next state is IDLE; sample_out=0 next cycle; rom_addr=0.
  - No done pulse.
- start while busy: ignored.
- start and stop in the same cycle from IDLE: stop wins, stay IDLE.
- busy = (state != IDLE).

Test Plan:
- Params BEAT_CYCLES=20, LAST_ADDR=3, ROM_LATENCY=2, AMPLITUDE=1000.
  1. Normal playback: ROM={4,0,2,9}, loop_en=0, start, audio_out_allowed=1.
     - Note 0: sample_out alternates +1000/-1000 every 5 clocks.
     - Note 1: 20 cycles of 0.
     - Note 2: toggles every 3 clocks.
     - Note 3: toggles every 10 clocks.
     - done pulses once, 4*(20+2)+1 cycles after start; then busy=0 and sample_out=0.
- Loop: same ROM, loop_en=1 → rom_addr sequence 0,1,2,3,0,1 with no done pulse; note 0 restarts with sample_out=+1000.
- End marker: ROM={4,7FFFF,...} → exactly one beat of tone, then IDLE with done=1; rom_addr never reaches 2.
- Abort and start rules:
  - stop mid-PLAY of note 2 → next cycle busy=0, sample_out=0, rom_addr=0, done=0.
  - start and stop together from IDLE → busy stays 0.
  - start while busy → playback unaffected.
- Volume and backpressure:
  - vol_shift=3 → samples ±125.
  - audio_out_allowed=0 for 7 cycles → write_audio_out=0 for those cycles; note timing is unchanged (done cycle identical to scenario 1).
- Reset mid-FETCH → next cycle all outputs at their reset values; a subsequent start replays from address 0.
